// File: rtl/link_pkg.sv
// Shared definitions for the serial link: default frame width, receiver
// state encoding and line levels.
package link_pkg;

    localparam int WIDTH_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } rx_state_t;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Serial input plus parallel valid/ready output bundle of the frame receiver.
// master = receiver side, slave = line driver / word consumer side.
interface serial_frame_rx_if #(
    parameter int WIDTH = link_pkg::WIDTH_DEFAULT
);
    logic             sIn;
    logic [WIDTH-1:0] pOut;
    logic             pValid;
    logic             pReady;
    logic             frameErr;
    logic             overrun;

    modport master (
        input  sIn,
        input  pReady,
        output pOut,
        output pValid,
        output frameErr,
        output overrun
    );

    modport slave (
        output sIn,
        output pReady,
        input  pOut,
        input  pValid,
        input  frameErr,
        input  overrun
    );
endinterface

// File: rtl/s2p_shift.sv
// Serial-in/parallel-out shift register, MSB first; mirror of the transmit shifter.
module s2p_shift #(
    parameter int WIDTH = link_pkg::WIDTH_DEFAULT
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    // Clear wins over shift so a new start bit always begins from zero.
    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], sin};
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, WIDTH data bits MSB first, stop bit;
// single-entry output register with valid/ready, framing-error and overrun pulses.
module serial_frame_rx
    import link_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                Clock,
    input  logic                rst,
    serial_frame_rx_if.master   link
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    rx_state_t        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] pout_q;
    logic             pvalid_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             sr_clr;
    logic             sr_en;

    assign sr_clr = (state == IDLE) && (link.sIn == START_BIT);
    assign sr_en  = (state == DATA);

    s2p_shift #(.WIDTH(WIDTH)) u_shift (
        .Clock (Clock),
        .rst   (rst),
        .clr   (sr_clr),
        .en    (sr_en),
        .sin   (link.sIn),
        .q     (word)
    );

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            pout_q      <= '0;
            pvalid_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // A pop may coincide with a commit below; the commit then overrides.
            if (pvalid_q && link.pReady) begin
                pvalid_q <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (link.sIn == START_BIT) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // A 1 here is a bad stop bit, never a new start bit.
                    state <= IDLE;
                    if (link.sIn == STOP_BIT) begin
                        if (!pvalid_q || link.pReady) begin
                            pout_q   <= word;
                            pvalid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign link.pOut     = pout_q;
    assign link.pValid   = pvalid_q;
    assign link.frameErr = frame_err_q;
    assign link.overrun  = overrun_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: vector table of frames plus hand-written
// sequences for latency, back-to-back frames and mid-frame reset.
module tb_serial_frame_rx;
    import link_pkg::*;

    localparam int WIDTH = 10;

    logic Clock;
    logic rst;

    serial_frame_rx_if #(.WIDTH(WIDTH)) link ();

    serial_frame_rx #(.WIDTH(WIDTH)) dut (
        .Clock (Clock),
        .rst   (rst),
        .link  (link.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             stop;
        logic             rdy;
        logic [WIDTH-1:0] exp_pout;
        logic             exp_v;
        logic             exp_fe;
        logic             exp_ov;
    } vec_t;

    vec_t tbl [8];
    int   vectors;
    int   miscompares;

    task automatic check(input string name, input logic [WIDTH-1:0] ep,
                         input logic ev, input logic efe, input logic eov);
        vectors++;
        if (link.pOut !== ep || link.pValid !== ev ||
            link.frameErr !== efe || link.overrun !== eov) begin
            miscompares++;
            $display("FAIL %s: got pOut=%h pValid=%b frameErr=%b overrun=%b, want pOut=%h pValid=%b frameErr=%b overrun=%b",
                     name, link.pOut, link.pValid, link.frameErr, link.overrun,
                     ep, ev, efe, eov);
        end
    endtask

    task automatic send_bit(input logic b, input logic rdy);
        link.sIn    = b;
        link.pReady = rdy;
        @(posedge Clock);
        #1;
    endtask

    task automatic send_data(input logic [WIDTH-1:0] w, input logic rdy);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(w[i], rdy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        //          data      stop  rdy   pOut      v     fe    ov
        tbl[0] = '{10'h214, 1'b0, 1'b0, 10'h214, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{10'h001, 1'b0, 1'b0, 10'h214, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{10'h0AA, 1'b0, 1'b1, 10'h0AA, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{10'h155, 1'b1, 1'b0, 10'h0AA, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{10'h3FF, 1'b0, 1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{10'h155, 1'b1, 1'b1, 10'h3FF, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{10'h0AA, 1'b0, 1'b0, 10'h0AA, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{10'h2AA, 1'b0, 1'b1, 10'h2AA, 1'b1, 1'b0, 1'b0};

        rst         = 1'b1;
        link.sIn    = IDLE_LEVEL;
        link.pReady = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset", '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single frame: valid appears exactly on the stop-bit edge.
        send_bit(IDLE_LEVEL, 1'b0);
        send_bit(START_BIT, 1'b0);
        send_data(10'h214, 1'b0);
        check("tp1_before_stop", '0, 1'b0, 1'b0, 1'b0);
        send_bit(STOP_BIT, 1'b0);
        check("tp1_commit", 10'h214, 1'b1, 1'b0, 1'b0);
        send_bit(IDLE_LEVEL, 1'b1);
        check("tp1_pop", 10'h214, 1'b0, 1'b0, 1'b0);

        // Back-to-back frames with pReady held high.
        send_bit(START_BIT, 1'b1);
        send_data(10'h214, 1'b1);
        send_bit(STOP_BIT, 1'b1);
        check("b2b_word1", 10'h214, 1'b1, 1'b0, 1'b0);
        send_bit(START_BIT, 1'b1);
        check("b2b_word1_len", 10'h214, 1'b0, 1'b0, 1'b0);
        send_data(10'h3FF, 1'b1);
        send_bit(STOP_BIT, 1'b1);
        check("b2b_word2", 10'h3FF, 1'b1, 1'b0, 1'b0);
        send_bit(IDLE_LEVEL, 1'b1);
        check("b2b_word2_len", 10'h3FF, 1'b0, 1'b0, 1'b0);

        // Table: pReady only asserted on the stop-bit edge; one idle cycle after.
        for (int v = 0; v < 8; v++) begin
            send_bit(START_BIT, 1'b0);
            send_data(tbl[v].data, 1'b0);
            send_bit(tbl[v].stop, tbl[v].rdy);
            check($sformatf("vec%0d", v), tbl[v].exp_pout, tbl[v].exp_v,
                  tbl[v].exp_fe, tbl[v].exp_ov);
            send_bit(IDLE_LEVEL, 1'b0);
            check($sformatf("vec%0d_flags_clear", v), tbl[v].exp_pout,
                  tbl[v].exp_v, 1'b0, 1'b0);
        end

        // Reset mid-DATA after 5 data bits, asserted between edges.
        send_bit(START_BIT, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send_bit(i[0], 1'b0);
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", '0, 1'b0, 1'b0, 1'b0);
        link.sIn = 1'b1;
        @(posedge Clock);
        #1;
        rst      = 1'b0;
        link.sIn = IDLE_LEVEL;
        send_bit(IDLE_LEVEL, 1'b0);
        check("rst_no_partial", '0, 1'b0, 1'b0, 1'b0);
        send_bit(START_BIT, 1'b0);
        send_data(10'h2AA, 1'b0);
        send_bit(STOP_BIT, 1'b0);
        check("rst_then_frame", 10'h2AA, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
